// File: rtl/ifetch_unit.sv
// Instruction fetch stage: issues word reads from the PC, tags returned
// words with their PC, buffers up to two of them for decode, and drops
// words that were in flight when a redirect happened.
module ifetch_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pc_in,
  output logic                  pc_stall,
  input  logic                  flush,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc,
  output logic                  exc_misaligned
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Outstanding = granted and still owed to the buffer; discard = granted
  // before a redirect, to be dropped on return. Both share the tag FIFO,
  // and discards are always the older entries.
  logic [1:0] out_q, out_d;
  logic [1:0] disc_q, disc_d;

  logic [DATA_WIDTH-1:0] tag_q [2];
  logic [DATA_WIDTH-1:0] tag_d [2];
  logic                  tag_wp_q, tag_wp_d;
  logic                  tag_rp_q, tag_rp_d;

  logic [DATA_WIDTH-1:0] buf_instr_q [2];
  logic [DATA_WIDTH-1:0] buf_instr_d [2];
  logic [DATA_WIDTH-1:0] buf_pc_q [2];
  logic [DATA_WIDTH-1:0] buf_pc_d [2];
  logic                  buf_wp_q, buf_wp_d;
  logic                  buf_rp_q, buf_rp_d;
  logic [1:0]            buf_cnt_q, buf_cnt_d;

  logic exc_q, exc_d;

  logic                  misaligned;
  logic [2:0]            credit_used;
  logic                  credit_ok;
  logic                  fetch_ok;
  logic                  accept;
  logic                  rsp_from_disc;
  logic                  rsp_from_out;
  logic                  keep_word;
  logic                  pop;
  logic [1:0]            out_left;
  logic [1:0]            disc_left;
  logic [DATA_WIDTH-1:0] rsp_tag;

  assign misaligned  = |pc_in[1:0];
  // Words in flight (kept or to be dropped) plus words already buffered
  // must never exceed the buffer capacity, so a response always has room.
  assign credit_used = {1'b0, out_q} + {1'b0, disc_q} + {1'b0, buf_cnt_q};
  assign credit_ok   = credit_used < 3'(DEPTH);
  assign fetch_ok    = !flush && !misaligned && credit_ok;
  assign accept      = imem_req && imem_gnt;

  assign rsp_from_disc = imem_rvalid && (disc_q != 2'd0);
  assign rsp_from_out  = imem_rvalid && (disc_q == 2'd0);
  assign keep_word     = rsp_from_out && !flush;
  assign rsp_tag       = tag_q[tag_rp_q];

  assign instr_valid    = buf_cnt_q != 2'd0;
  assign pop            = instr_valid && instr_ready;
  assign instr          = buf_instr_q[buf_rp_q];
  assign instr_pc       = buf_pc_q[buf_rp_q];
  assign imem_addr      = pc_in;
  assign exc_misaligned = exc_q;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // FSM next state: one idle cycle out of reset, halt on a misaligned PC
  // until a redirect arrives
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_RUN;
      S_RUN:   if (!flush && misaligned) state_d = S_HALT;
      S_HALT:  if (flush) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: request/stall generation and the misalignment pulse
  always_comb begin
    imem_req = 1'b0;
    pc_stall = 1'b1;
    exc_d    = 1'b0;
    case (state_q)
      S_RUN: begin
        imem_req = fetch_ok;
        pc_stall = !((fetch_ok && imem_gnt) || flush);
        exc_d    = !flush && misaligned;
      end
      S_HALT:  pc_stall = !flush;
      default: ;
    endcase
  end

  // In-flight bookkeeping: a response retires a discard first; a redirect
  // turns everything still outstanding into discards
  always_comb begin
    out_left  = out_q - {1'b0, rsp_from_out};
    disc_left = disc_q - {1'b0, rsp_from_disc};
    if (flush) begin
      out_d  = 2'd0;
      disc_d = disc_left + out_left;
    end else begin
      out_d  = out_left + {1'b0, accept};
      disc_d = disc_left;
    end
  end

  // Tag FIFO: PC pushed on grant, popped on every response
  always_comb begin
    tag_d    = tag_q;
    tag_wp_d = tag_wp_q ^ accept;
    tag_rp_d = tag_rp_q ^ imem_rvalid;
    if (accept) tag_d[tag_wp_q] = pc_in;
  end

  // Instruction buffer: write kept responses, pop on decode handshake,
  // empty on redirect
  always_comb begin
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    buf_wp_d    = buf_wp_q;
    buf_rp_d    = buf_rp_q;
    buf_cnt_d   = buf_cnt_q;
    if (flush) begin
      buf_cnt_d = 2'd0;
      buf_rp_d  = buf_wp_q;
    end else begin
      if (keep_word) begin
        buf_instr_d[buf_wp_q] = imem_rdata;
        buf_pc_d[buf_wp_q]    = rsp_tag;
        buf_wp_d              = ~buf_wp_q;
      end
      if (pop) buf_rp_d = ~buf_rp_q;
      buf_cnt_d = buf_cnt_q + {1'b0, keep_word} - {1'b0, pop};
    end
  end

  // Datapath and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q       <= 2'd0;
      disc_q      <= 2'd0;
      tag_q       <= '{default: '0};
      tag_wp_q    <= 1'b0;
      tag_rp_q    <= 1'b0;
      buf_instr_q <= '{default: '0};
      buf_pc_q    <= '{default: '0};
      buf_wp_q    <= 1'b0;
      buf_rp_q    <= 1'b0;
      buf_cnt_q   <= 2'd0;
      exc_q       <= 1'b0;
    end else begin
      out_q       <= out_d;
      disc_q      <= disc_d;
      tag_q       <= tag_d;
      tag_wp_q    <= tag_wp_d;
      tag_rp_q    <= tag_rp_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      buf_wp_q    <= buf_wp_d;
      buf_rp_q    <= buf_rp_d;
      buf_cnt_q   <= buf_cnt_d;
      exc_q       <= exc_d;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: a PC model and a one-cycle-latency
// instruction memory surround the DUT; expected values are hand-derived.
module tb_ifetch_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] pc_in = '0;
  logic         pc_stall;
  logic         flush = 1'b0;
  logic         imem_req;
  logic [W-1:0] imem_addr;
  logic         imem_gnt = 1'b1;
  logic         imem_rvalid = 1'b0;
  logic [W-1:0] imem_rdata = '0;
  logic         instr_valid;
  logic         instr_ready = 1'b1;
  logic [W-1:0] instr;
  logic [W-1:0] instr_pc;
  logic         exc_misaligned;

  ifetch_unit #(.DATA_WIDTH(W), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_stall(pc_stall), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .exc_misaligned(exc_misaligned)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] pc;
  logic [W-1:0] flush_tgt = '0;
  logic         rv_en = 1'b1;
  logic [W-1:0] pending [$];

  logic         s_req, s_stall, s_val, s_exc;
  logic [W-1:0] s_addr, s_instr, s_ipc;

  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    return {a[23:0], 8'h13};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_mem();
    pc_in       = pc;
    imem_rvalid = rv_en && (pending.size() != 0);
    imem_rdata  = imem_rvalid ? mem_word(pending[0]) : '0;
  endtask

  task automatic mid();
    @(negedge clk);
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_stall = pc_stall;
    s_val   = instr_valid;
    s_instr = instr;
    s_ipc   = instr_pc;
    s_exc   = exc_misaligned;
  endtask

  task automatic edge_();
    logic g, r;
    g = s_req && imem_gnt;
    r = imem_rvalid;
    @(posedge clk);
    #1;
    if (r) void'(pending.pop_front());
    if (g) pending.push_back(s_addr);
    if (flush) pc = flush_tgt;
    else if (!s_stall) pc = pc + 32'd4;
    flush = 1'b0;
    drive_mem();
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    flush       = 1'b0;
    imem_gnt    = 1'b1;
    instr_ready = 1'b1;
    rv_en       = 1'b1;
    pending.delete();
    pc = '0;
    drive_mem();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      mid();
      edge_();
    end
  endtask

  always @(posedge clk)
    if (rst && imem_rvalid) assert (pending.size() != 0) else $error("rvalid with no tag outstanding");

  initial begin
    pc = '0;
    #1 rst = 1'b0;
    #1;
    chk("rst_req",   imem_req,       0);
    chk("rst_stall", pc_stall,       1);
    chk("rst_valid", instr_valid,    0);
    chk("rst_instr", instr,          0);
    chk("rst_ipc",   instr_pc,       0);
    chk("rst_exc",   exc_misaligned, 0);

    // Streaming fetch with immediate grant and 1-cycle memory latency
    do_reset();
    mid(); chk("idle_req", s_req, 0); chk("idle_stall", s_stall, 1); edge_();
    mid(); chk("s1_req0", s_req, 1); chk("s1_addr0", s_addr, 32'h0);
    chk("s1_stall0", s_stall, 0); chk("s1_val0", s_val, 0); edge_();
    mid(); chk("s1_req1", s_req, 1); chk("s1_addr1", s_addr, 32'h4); edge_();
    mid(); chk("s1_val2", s_val, 1); chk("s1_ipc2", s_ipc, 32'h0);
    chk("s1_instr2", s_instr, 32'h00000013); chk("s1_credit", s_req, 0); edge_();
    mid(); chk("s1_ipc3", s_ipc, 32'h4); chk("s1_instr3", s_instr, 32'h00000413);
    chk("s1_req3", s_req, 1); chk("s1_addr3", s_addr, 32'h8);

    // Asynchronous reset mid-cycle with a request and a buffered word live
    #1 rst = 1'b0;
    #1;
    chk("ar_req",   imem_req,    0);
    chk("ar_valid", instr_valid, 0);
    chk("ar_stall", pc_stall,    1);
    chk("ar_ipc",   instr_pc,    0);
    do_reset();
    mid(); chk("ar_idle_val", s_val, 0); edge_();
    mid(); chk("ar_req0", s_req, 1); chk("ar_addr0", s_addr, 32'h0); chk("ar_val0", s_val, 0); edge_();
    mid(); chk("ar_val1", s_val, 0); edge_();
    mid(); chk("ar_val2", s_val, 1); chk("ar_ipc2", s_ipc, 32'h0); edge_();

    // Decode back-pressure fills the buffer and stalls the PC
    do_reset();
    instr_ready = 1'b0;
    cyc(3);
    mid(); chk("bp_val2", s_val, 1); chk("bp_ipc2", s_ipc, 32'h0); edge_();
    mid(); chk("bp_req3", s_req, 0); chk("bp_stall3", s_stall, 1);
    chk("bp_addr3", s_addr, 32'h8); chk("bp_ipc3", s_ipc, 32'h0); edge_();
    cyc(2);
    mid(); chk("bp_ipc6", s_ipc, 32'h0); chk("bp_stall6", s_stall, 1);
    instr_ready = 1'b1;
    edge_();
    mid(); chk("bp_ipc7", s_ipc, 32'h4); chk("bp_instr7", s_instr, 32'h00000413);
    chk("bp_val7", s_val, 1); edge_();

    // Grant withheld for three cycles at PC 0x4
    do_reset();
    cyc(2);
    imem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("ng_req", s_req, 1); chk("ng_addr", s_addr, 32'h4); chk("ng_stall", s_stall, 1);
      edge_();
    end
    imem_gnt = 1'b1;
    mid(); chk("ng_go_addr", s_addr, 32'h4); chk("ng_go_stall", s_stall, 0); edge_();
    mid(); chk("ng_next_req", s_req, 1); chk("ng_next_addr", s_addr, 32'h8); edge_();

    // Redirect with two reads outstanding: both returns are dropped
    do_reset();
    rv_en = 1'b0;
    drive_mem();
    cyc(3);
    flush = 1'b1;
    flush_tgt = 32'h14;
    mid(); chk("fl_req", s_req, 0); chk("fl_stall", s_stall, 0); edge_();
    rv_en = 1'b1;
    drive_mem();
    mid(); chk("fl_val3", s_val, 0); chk("fl_req3", s_req, 0); edge_();
    mid(); chk("fl_val4", s_val, 0); chk("fl_req4", s_req, 1); chk("fl_addr4", s_addr, 32'h14); edge_();
    mid(); chk("fl_val5", s_val, 0); edge_();
    mid(); chk("fl_val6", s_val, 1); chk("fl_ipc6", s_ipc, 32'h14);
    chk("fl_instr6", s_instr, 32'h00001413); edge_();

    // Misaligned PC halts fetch until a redirect
    do_reset();
    cyc(1);
    flush = 1'b1;
    flush_tgt = 32'h22;
    mid(); chk("ma_redir_req", s_req, 0); edge_();
    mid(); chk("ma_req1", s_req, 0); chk("ma_stall1", s_stall, 1); chk("ma_exc1", s_exc, 0); edge_();
    mid(); chk("ma_exc2", s_exc, 1); chk("ma_req2", s_req, 0); chk("ma_stall2", s_stall, 1); edge_();
    mid(); chk("ma_exc3", s_exc, 0); chk("ma_req3", s_req, 0); chk("ma_stall3", s_stall, 1); edge_();
    flush = 1'b1;
    flush_tgt = 32'h24;
    mid(); chk("ma_fl_stall", s_stall, 0); chk("ma_fl_req", s_req, 0); edge_();
    mid(); chk("ma_res_req", s_req, 1); chk("ma_res_addr", s_addr, 32'h24); edge_();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
